// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory: access encodings,
// lane geometry and the default array depth.
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_LH   = 3'd2,
    MEM_LHU  = 3'd3,
    MEM_LB   = 3'd4,
    MEM_LBU  = 3'd5,
    MEM_SW   = 3'd6,
    MEM_SH   = 3'd7
  } mem_op_e;

  localparam int LANE_BITS   = 8;
  localparam int HALF_BITS   = 16;
  localparam int WORD_BITS   = 32;
  localparam int DEPTH_WORDS_DEF = 4096;

  function automatic logic op_is_load(mem_op_e op);
    return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LHU) ||
           (op == MEM_LB) || (op == MEM_LBU);
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load-path lane extraction: picks the byte or half named by addr and
// sign/zero-extends it according to the load kind.
module dm_lane_ext
  import mem_pkg::*;
(
  input  logic [WORD_BITS-1:0] word,
  input  logic [1:0]           addr,
  input  mem_op_e              op,
  output logic [WORD_BITS-1:0] data
);

  logic [LANE_BITS-1:0] byte_v;
  logic [HALF_BITS-1:0] half_v;

  always_comb begin
    byte_v = word[LANE_BITS*addr +: LANE_BITS];
    half_v = addr[1] ? word[WORD_BITS-1:HALF_BITS] : word[HALF_BITS-1:0];
    data   = '0;
    case (op)
      MEM_LW:  data = word;
      MEM_LH:  data = {{(WORD_BITS-HALF_BITS){half_v[HALF_BITS-1]}}, half_v};
      MEM_LHU: data = {{(WORD_BITS-HALF_BITS){1'b0}}, half_v};
      MEM_LB:  data = {{(WORD_BITS-LANE_BITS){byte_v[LANE_BITS-1]}}, byte_v};
      MEM_LBU: data = {{(WORD_BITS-LANE_BITS){1'b0}}, byte_v};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: combinational loads, edge-committed merged stores,
// error flagging for misaligned/out-of-range accesses, and a store log.
module mem_stage_dm
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int IDX_W       = 12
)(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] addM,
  input  logic [31:0] wdataM,
  input  logic [31:0] PCM,
  input  logic [2:0]  mem_op,
  input  logic        sb_en,
  output logic [31:0] rdataM,
  output logic        mem_err
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  mem_op_e          op_in;
  mem_op_e          eff_op;
  logic             is_sb;
  logic             is_load;
  logic             is_store;
  logic             misaligned;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [31:0]      ext_data;
  logic [31:0]      merged;
  logic             store_ok;

  assign op_in  = mem_op_e'(mem_op);
  // sb_en only means "byte store" alongside NONE; with any other op the access is void
  assign eff_op = sb_en ? MEM_NONE : op_in;
  assign is_sb  = sb_en && (op_in == MEM_NONE);

  assign is_load  = op_is_load(eff_op);
  assign is_store = is_sb || (eff_op == MEM_SW) || (eff_op == MEM_SH);

  always_comb begin
    misaligned = 1'b0;
    case (eff_op)
      MEM_LW, MEM_SW:          misaligned = (addM[1:0] != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: misaligned = addM[0];
      default:                 misaligned = 1'b0;
    endcase
  end

  assign in_range = ({1'b0, addM} < ADDR_LIMIT);
  assign mem_err  = (is_load || is_store) && (misaligned || !in_range);

  assign idx     = addM[IDX_W+1:2];
  assign rd_word = mem[idx];

  dm_lane_ext u_ext (
    .word (rd_word),
    .addr (addM[1:0]),
    .op   (eff_op),
    .data (ext_data)
  );

  assign rdataM = (is_load && !mem_err) ? ext_data : '0;

  always_comb begin
    merged = rd_word;
    if (eff_op == MEM_SW) begin
      merged = wdataM;
    end else if (eff_op == MEM_SH) begin
      merged[HALF_BITS*addM[1] +: HALF_BITS] = wdataM[HALF_BITS-1:0];
    end else if (is_sb) begin
      merged[LANE_BITS*addM[1:0] +: LANE_BITS] = wdataM[LANE_BITS-1:0];
    end
  end

  assign store_ok = is_store && !mem_err;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (store_ok) begin
      mem[idx] <= merged;
`ifndef SYNTHESIS
      $display("%d@%h: *%h <= %h", $time, PCM, {addM[31:2], 2'b00}, merged);
`endif
    end
  end

endmodule
